// File: rtl/msx_cartbus_pkg.sv
// Shared types and defaults for the MSX cartridge-bus front-end.
package msx_cartbus_pkg;

  // Bus access sequencer states.
  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    WR_REQ   = 3'd1,
    RD_REQ   = 3'd2,
    RD_DRIVE = 3'd3,
    RELEASE  = 3'd4
  } state_t;

  // Value returned to the MSX when the decoder never answers a read.
  localparam logic [7:0] OPEN_BUS_DATA_DEFAULT = 8'hFF;

  // Fewest synchroniser stages that still give a usable MTBF.
  localparam int unsigned SYNC_STAGES_MIN = 2;

endpackage : msx_cartbus_pkg

// File: rtl/msx_sync_edge.sv
// N-stage synchroniser for one asynchronous level, plus a rising-edge
// pulse of the synchronised level.
module msx_sync_edge #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk,
  input  logic i_async,
  output logic o_level,
  output logic o_rise
);

  logic [STAGES-1:0] r_sync;
  logic              r_prev;

  // Shift the pin through the synchroniser chain and keep the last level for edge detection.
  // NOTE: the chain is deliberately not reset -- it must keep tracking the
  // pin through reset so a strobe held across reset is not seen as a new edge.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every flop samples the pre-edge value.
    r_sync <= {r_sync[STAGES-2:0], i_async};
    r_prev <= r_sync[STAGES-1];
  end

  assign o_level = r_sync[STAGES-1];
  assign o_rise  = r_sync[STAGES-1] & ~r_prev;

endmodule : msx_sync_edge

// File: rtl/msx_cartbus_if.sv
// MSX cartridge-bus front-end: synchronises the pin strobes, issues one
// valid/ready transaction per access, returns read data on td and drives
// tdir/twait for the level shifter and the Z80 wait line.
module msx_cartbus_if
  import msx_cartbus_pkg::*;
#(
  parameter int unsigned SYNC_STAGES    = 2,
  parameter int unsigned TIMEOUT_CYCLES = 64,
  parameter logic [7:0]  OPEN_BUS_DATA  = OPEN_BUS_DATA_DEFAULT
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       n_ce,
  input  logic       n_twr,
  input  logic       n_trd,
  input  logic [1:0] ta,
  input  logic [7:0] td_in,
  output logic [7:0] td_out,
  output logic       td_oe,
  output logic       tdir,
  output logic       twait,
  output logic       bus_valid,
  input  logic       bus_ready,
  output logic       bus_write,
  output logic [1:0] bus_address,
  output logic [7:0] bus_wdata,
  input  logic [7:0] bus_rdata
);

  localparam int unsigned SYNC_N = (SYNC_STAGES < SYNC_STAGES_MIN) ? SYNC_STAGES_MIN : SYNC_STAGES;
  localparam int unsigned CNT_W  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] TCNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  // Synchronised strobes, expressed in their active (asserted = 1) sense.
  logic w_ce_act,  w_ce_rise;
  logic w_twr_act, w_twr_rise;
  logic w_trd_act, w_trd_rise;

  msx_sync_edge #(.STAGES(SYNC_N)) u_sync_ce (
    .clk     (clk),
    .i_async (~n_ce),
    .o_level (w_ce_act),
    .o_rise  (w_ce_rise)
  );

  msx_sync_edge #(.STAGES(SYNC_N)) u_sync_twr (
    .clk     (clk),
    .i_async (~n_twr),
    .o_level (w_twr_act),
    .o_rise  (w_twr_rise)
  );

  msx_sync_edge #(.STAGES(SYNC_N)) u_sync_trd (
    .clk     (clk),
    .i_async (~n_trd),
    .o_level (w_trd_act),
    .o_rise  (w_trd_rise)
  );

  // An access term rises when both its inputs are now active and at least
  // one of them has just become active.
  logic w_wr_act, w_rd_act, w_wr_rise, w_rd_rise;
  assign w_wr_act  = w_ce_act & w_twr_act;
  assign w_rd_act  = w_ce_act & w_trd_act;
  assign w_wr_rise = w_wr_act & (w_ce_rise | w_twr_rise);
  assign w_rd_rise = w_rd_act & (w_ce_rise | w_trd_rise);

  state_t           r_state,       w_state_nxt;
  logic             r_bus_valid,   w_bus_valid_nxt;
  logic             r_bus_write,   w_bus_write_nxt;
  logic [1:0]       r_bus_address, w_bus_address_nxt;
  logic [7:0]       r_bus_wdata,   w_bus_wdata_nxt;
  logic [7:0]       r_td_out,      w_td_out_nxt;
  logic             r_td_oe,       w_td_oe_nxt;
  logic             r_tdir,        w_tdir_nxt;
  logic             r_twait,       w_twait_nxt;
  logic [CNT_W-1:0] r_tcnt,        w_tcnt_nxt;
  // Sticky: a write strobe arrived while the previous write was still pending.
  logic             r_wr_overrun,  w_wr_overrun_nxt;

  // Next-state and next-output decode for the access sequencer.
  always_comb begin
    // NOTE: every target gets a hold-value default first so no path infers a latch.
    w_state_nxt       = r_state;
    w_bus_valid_nxt   = r_bus_valid;
    w_bus_write_nxt   = r_bus_write;
    w_bus_address_nxt = r_bus_address;
    w_bus_wdata_nxt   = r_bus_wdata;
    w_td_out_nxt      = r_td_out;
    w_td_oe_nxt       = r_td_oe;
    w_tdir_nxt        = r_tdir;
    w_twait_nxt       = r_twait;
    w_tcnt_nxt        = r_tcnt;
    w_wr_overrun_nxt  = r_wr_overrun;

    unique case (r_state)
      IDLE: begin
        // Write has priority when both strobes appear in the same cycle.
        if (w_wr_rise) begin
          w_bus_address_nxt = ta;
          w_bus_wdata_nxt   = td_in;
          w_bus_write_nxt   = 1'b1;
          w_bus_valid_nxt   = 1'b1;
          w_state_nxt       = WR_REQ;
        end else if (w_rd_rise) begin
          w_bus_address_nxt = ta;
          w_bus_write_nxt   = 1'b0;
          w_bus_valid_nxt   = 1'b1;
          w_twait_nxt       = 1'b1;
          w_tcnt_nxt        = '0;
          w_state_nxt       = RD_REQ;
        end
      end

      WR_REQ: begin
        if (w_wr_rise) begin
          w_wr_overrun_nxt = 1'b1;
        end
        if (bus_ready) begin
          w_bus_valid_nxt = 1'b0;
          w_state_nxt     = RELEASE;
        end
      end

      RD_REQ: begin
        if (bus_ready || (r_tcnt == TCNT_LAST)) begin
          w_td_out_nxt    = bus_ready ? bus_rdata : OPEN_BUS_DATA;
          w_td_oe_nxt     = 1'b1;
          w_tdir_nxt      = 1'b1;
          w_twait_nxt     = 1'b0;
          w_bus_valid_nxt = 1'b0;
          w_state_nxt     = RD_DRIVE;
        end else begin
          // Below TCNT_LAST here, so the increment can never wrap.
          w_tcnt_nxt = r_tcnt + 1'b1;
        end
      end

      RD_DRIVE: begin
        // Release the data pins first; the direction flips a cycle later.
        if (!w_rd_act) begin
          w_td_oe_nxt = 1'b0;
          w_state_nxt = RELEASE;
        end
      end

      RELEASE: begin
        w_tdir_nxt = 1'b0;
        if (!w_wr_act && !w_rd_act) begin
          w_state_nxt = IDLE;
        end
      end

      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= IDLE;
      r_bus_valid   <= 1'b0;
      r_bus_write   <= 1'b0;
      r_bus_address <= '0;
      r_bus_wdata   <= '0;
      r_td_out      <= 8'hFF;
      r_td_oe       <= 1'b0;
      r_tdir        <= 1'b0;
      r_twait       <= 1'b0;
      r_tcnt        <= '0;
      r_wr_overrun  <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_bus_valid   <= w_bus_valid_nxt;
      r_bus_write   <= w_bus_write_nxt;
      r_bus_address <= w_bus_address_nxt;
      r_bus_wdata   <= w_bus_wdata_nxt;
      r_td_out      <= w_td_out_nxt;
      r_td_oe       <= w_td_oe_nxt;
      r_tdir        <= w_tdir_nxt;
      r_twait       <= w_twait_nxt;
      r_tcnt        <= w_tcnt_nxt;
      r_wr_overrun  <= w_wr_overrun_nxt;
    end
  end

  assign bus_valid   = r_bus_valid;
  assign bus_write   = r_bus_write;
  assign bus_address = r_bus_address;
  assign bus_wdata   = r_bus_wdata;
  assign td_out      = r_td_out;
  assign td_oe       = r_td_oe;
  assign tdir        = r_tdir;
  assign twait       = r_twait;

endmodule : msx_cartbus_if

// File: tb/tb_msx_cartbus_if.sv
// Self-checking bench for msx_cartbus_if: directed accesses from the test
// plan followed by randomized reads and writes against a simple model.
module tb_msx_cartbus_if;

  localparam int         SYNC     = 2;
  localparam int         TIMEOUT  = 64;
  localparam logic [7:0] OPEN_BUS = 8'hFF;
  localparam int         LAT_PIN  = SYNC + 1;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       n_ce = 1'b1;
  logic       n_twr = 1'b1;
  logic       n_trd = 1'b1;
  logic [1:0] ta = '0;
  logic [7:0] td_in = '0;
  logic       bus_ready = 1'b0;
  logic [7:0] bus_rdata = '0;

  logic [7:0] td_out;
  logic       td_oe, tdir, twait;
  logic       bus_valid, bus_write;
  logic [1:0] bus_address;
  logic [7:0] bus_wdata;

  int n_vec  = 0;
  int n_miss = 0;

  // Passive monitor state (updated on posedge from pre-edge values).
  int         mon_valid_rises = 0;
  logic       mon_prev_valid  = 1'b0;
  int         acc_n = 0;
  logic       acc_write = 1'b0;
  logic [1:0] acc_addr = '0;
  logic [7:0] acc_wdata = '0;

  // Per-read state shared between read_access and read_release.
  int         rd_rises0;
  logic [7:0] rd_exp_td;

  always #5 clk = ~clk;

  msx_cartbus_if #(
    .SYNC_STAGES    (SYNC),
    .TIMEOUT_CYCLES (TIMEOUT),
    .OPEN_BUS_DATA  (OPEN_BUS)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .n_ce        (n_ce),
    .n_twr       (n_twr),
    .n_trd       (n_trd),
    .ta          (ta),
    .td_in       (td_in),
    .td_out      (td_out),
    .td_oe       (td_oe),
    .tdir        (tdir),
    .twait       (twait),
    .bus_valid   (bus_valid),
    .bus_ready   (bus_ready),
    .bus_write   (bus_write),
    .bus_address (bus_address),
    .bus_wdata   (bus_wdata),
    .bus_rdata   (bus_rdata)
  );

  // Count bus_valid pulses and record every accepted handshake.
  always @(posedge clk) begin
    if (bus_valid && !mon_prev_valid) mon_valid_rises = mon_valid_rises + 1;
    mon_prev_valid = bus_valid;
    if (bus_valid && bus_ready) begin
      acc_n     = acc_n + 1;
      acc_write = bus_write;
      acc_addr  = bus_address;
      acc_wdata = bus_wdata;
    end
  end

  // Reference model: cycles of twait and the byte driven back for a read
  // whose decoder answers `lat` cycles after bus_valid is first visible.
  function automatic int exp_twait_cycles(input int lat);
    return (lat + 1 < TIMEOUT) ? lat + 1 : TIMEOUT;
  endfunction

  function automatic logic [7:0] exp_read_byte(input int lat, input logic [7:0] rd);
    return (lat < TIMEOUT) ? rd : OPEN_BUS;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_miss++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    while (!bus_valid && n < 20) begin
      tick();
      n++;
    end
  endtask

  task automatic do_write(input logic [1:0] a, input logic [7:0] d, input int lat,
                          input int hold, input bit both);
    int   n, c, rises0, acc0;
    logic twait_seen, stable;
    rises0 = mon_valid_rises;
    acc0   = acc_n;
    ta     = a;
    td_in  = d;
    n_ce   = 1'b0;
    n_twr  = 1'b0;
    if (both) n_trd = 1'b0;
    twait_seen = 1'b0;
    wait_valid(n);
    check("wr_latency", n, LAT_PIN);
    check("wr_fields", {bus_write, bus_address, bus_wdata}, {1'b1, a, d});
    // The pins may wander once latched; the request must not follow them.
    ta    = 2'($urandom);
    td_in = 8'($urandom);
    c = 0;
    stable = 1'b1;
    while (bus_valid && c < 200) begin
      twait_seen |= twait;
      if ({bus_write, bus_address, bus_wdata} !== {1'b1, a, d}) stable = 1'b0;
      bus_ready = (c == lat);
      tick();
      c++;
    end
    bus_ready = 1'b0;
    check("wr_valid_cycles", c, lat + 1);
    check("wr_stable", stable, 1);
    repeat (hold) begin twait_seen |= twait; tick(); end
    n_ce  = 1'b1;
    n_twr = 1'b1;
    n_trd = 1'b1;
    repeat (8) begin twait_seen |= twait; tick(); end
    check("wr_twait", twait_seen, 0);
    check("wr_one_valid", mon_valid_rises - rises0, 1);
    check("wr_accepts", acc_n - acc0, 1);
    check("wr_acc_fields", {acc_write, acc_addr, acc_wdata}, {1'b1, a, d});
  endtask

  task automatic read_access(input logic [1:0] a, input int lat, input logic [7:0] rd);
    int   n, c, tw;
    logic done;
    rd_rises0 = mon_valid_rises;
    rd_exp_td = exp_read_byte(lat, rd);
    ta    = a;
    td_in = 8'($urandom);
    n_ce  = 1'b0;
    n_trd = 1'b0;
    wait_valid(n);
    check("rd_latency", n, LAT_PIN);
    check("rd_fields", {bus_write, bus_address, twait}, {1'b0, a, 1'b1});
    c = 0;
    tw = 0;
    done = 1'b0;
    while (!done && c < 200) begin
      if (td_oe) begin
        done = 1'b1;
      end else begin
        tw += int'(twait);
        bus_ready = bus_valid && (c == lat);
        bus_rdata = bus_ready ? rd : 8'($urandom);
        tick();
        c++;
      end
    end
    bus_ready = 1'b0;
    check("rd_done", done, 1);
    check("rd_twait_cycles", tw, exp_twait_cycles(lat));
    check("rd_drive", {td_oe, tdir, twait, bus_valid, td_out}, {4'b1100, rd_exp_td});
  endtask

  task automatic read_release(input int hold);
    int   k;
    logic ok;
    ok = 1'b1;
    repeat (hold) begin
      if ({td_oe, tdir, twait, td_out} !== {3'b110, rd_exp_td}) ok = 1'b0;
      tick();
    end
    check("rd_hold", ok, 1);
    n_trd = 1'b1;
    n_ce  = 1'b1;
    k = 0;
    while (td_oe && k < 20) begin
      tick();
      k++;
    end
    check("rd_oe_fall", k, LAT_PIN);
    check("rd_tdir_after_oe", tdir, 1);
    tick();
    check("rd_tdir_fall", tdir, 0);
    repeat (6) tick();
    check("rd_one_valid", mon_valid_rises - rd_rises0, 1);
  endtask

  initial begin
    logic [1:0] ra;
    logic [7:0] rd;
    int         rl;
    int         rises0;

    // Reset state.
    repeat (6) tick();
    check("reset_state",
          {td_oe, tdir, twait, bus_valid, bus_write, bus_address, bus_wdata, td_out},
          {5'b00000, 2'b00, 8'h00, 8'hFF});
    reset = 1'b0;
    repeat (4) tick();

    // Posted write, ready two cycles after valid, ~300 ns strobe.
    do_write(2'b01, 8'h5A, 2, 25, 1'b0);

    // Read answered after 5 cycles.
    read_access(2'b10, 5, 8'hC3);
    read_release(10);

    // Read with no answer: open-bus byte after the timeout.
    read_access(2'b00, 1000, 8'h12);
    read_release(5);

    // Long strobes: one transaction each.
    do_write(2'b11, 8'hA5, 0, 2000, 1'b0);
    read_access(2'b01, 3, 8'h77);
    read_release(2000);

    // Write and read strobes together: only the write is issued.
    do_write(2'b10, 8'h3C, 1, 4, 1'b1);

    // Reset while driving read data.
    read_access(2'b11, 1, 8'h96);
    rises0 = rd_rises0;
    repeat (3) tick();
    reset = 1'b1;
    tick();
    check("rst_in_drive",
          {td_oe, tdir, twait, bus_valid, bus_write, bus_address, bus_wdata, td_out},
          {5'b00000, 2'b00, 8'h00, 8'hFF});
    n_trd = 1'b1;
    n_ce  = 1'b1;
    repeat (5) tick();
    reset = 1'b0;
    repeat (6) tick();
    check("rst_no_new_valid", mon_valid_rises - rises0, 1);

    // Randomized accesses.
    for (int i = 0; i < 12; i++) begin
      ra = 2'($urandom);
      rd = 8'($urandom);
      if ($urandom_range(0, 1) == 1) begin
        do_write(ra, rd, $urandom_range(0, 6), $urandom_range(0, 20), 1'b0);
      end else begin
        rl = ($urandom_range(0, 3) == 0) ? $urandom_range(60, 70) : $urandom_range(0, 8);
        read_access(ra, rl, rd);
        read_release($urandom_range(0, 20));
      end
      repeat (4) tick();
    end

    check("wr_overrun_flag", dut.r_wr_overrun, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule : tb_msx_cartbus_if
